alu_seq: RTL and testbench

- Parametrised, multi-cycle successor to the 4-bit combinational ALU.
- Operations: add, sub, multiply, divide on WIDTH-bit operands.
- Start/busy/done handshake. Add/sub complete in one cycle; mul/div run iteratively.
- Registered result and flags. Sits between the operand register file and the writeback stage.

---
 rtl/alu_seq_pkg.sv | 24 ++
 rtl/alu_seq_iter.sv | 67 ++++++
 rtl/alu_seq.sv | 198 +++++++++++++++++++
 tb/tb_alu_seq.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Opcodes, FSM state encoding and build options shared by alu_seq and its datapath.
// Define ALU_SEQ_SIGNED_EN to enable two's-complement mul/div when signed_op=1.
package alu_seq_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDSUB = 3'd1,
        S_MUL    = 3'd2,
        S_DIV    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

`ifdef ALU_SEQ_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

endpackage

// File: rtl/alu_seq_iter.sv
// Shared iterative datapath: shift-add multiply and restoring divide on unsigned
// magnitudes. {hi, lo} is the product register; for division hi is the partial remainder.
module alu_seq_iter
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a_mag,
    input  logic [WIDTH-1:0] b_mag,
    output logic             first,
    output logic             last,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [WIDTH-1:0] m;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] trial;
    logic             fits;

    always_comb begin
        add_sum = {1'b0, hi} + (lo[0] ? {1'b0, m} : {(WIDTH + 1){1'b0}});
        shifted = {hi, lo[WIDTH-1]};
        // The partial remainder stays below the divisor, so the difference fits WIDTH bits.
        trial   = shifted[WIDTH-1:0] - m;
        fits    = (shifted >= {1'b0, m});
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            hi  <= '0;
            lo  <= '0;
            m   <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (load) begin
            hi  <= '0;
            lo  <= a_mag;
            m   <= b_mag;
            cnt <= CNT_W'(1);
        end else if (step) begin
            cnt <= cnt + CNT_W'(1);
            if (is_div) begin
                hi <= fits ? trial : shifted[WIDTH-1:0];
                lo <= {lo[WIDTH-2:0], fits};
            end else begin
                hi <= add_sum[WIDTH:1];
                lo <= {add_sum[0], lo[WIDTH-1:1]};
            end
        end
    end

    // cnt==0: operands not yet loaded; cnt==WIDTH: the final step is being taken.
    assign first = (cnt == '0);
    assign last  = (cnt == CNT_W'(WIDTH));

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle add/sub/mul/div unit with start/busy/done handshake and registered results.
// Define ALU_SEQ_SIGNED_EN to enable signed mul/div (signed_op=1); otherwise signed_op is ignored.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [1:0]         opcode,
    input  logic               signed_op,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic [WIDTH-1:0]   remainder,
    output logic               carry_flag,
    output logic               overflow_flag,
    output logic               div_by_zero_flag
);

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH - 1){1'b0}}};

    state_t             state;
    state_t             launch;
    logic [1:0]         op_q;
    logic               sgn_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;

    logic               iter_clear, iter_load, iter_step, iter_first, iter_last;
    logic [WIDTH-1:0]   a_mag, b_mag, hi, lo;

    logic               signed_mode, neg_a, neg_b, neg_q;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   diff, quot, rem;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     prod_top;
    logic               mul_wide, div_ovf;

    logic [2*WIDTH-1:0] pub_result;
    logic [WIDTH-1:0]   pub_rem;
    logic               pub_carry, pub_ovf, pub_dz;

    // Magnitude operation plus sign fix-up; folds away when the signed build is off.
    assign signed_mode = SIGNED_EN && sgn_q;
    assign neg_a       = signed_mode && a_q[WIDTH-1];
    assign neg_b       = signed_mode && b_q[WIDTH-1];
    assign neg_q       = neg_a ^ neg_b;
    assign a_mag       = neg_a ? -a_q : a_q;
    assign b_mag       = neg_b ? -b_q : b_q;

    assign sum      = {1'b0, a_q} + {1'b0, b_q};
    assign diff     = a_q - b_q;
    assign prod     = neg_q ? -{hi, lo} : {hi, lo};
    assign quot     = neg_q ? -lo : lo;
    assign rem      = neg_a ? -hi : hi;
    assign prod_top = prod[2*WIDTH-1:WIDTH-1];
    assign mul_wide = signed_mode ? !((&prod_top) || !(|prod_top)) : |prod[2*WIDTH-1:WIDTH];
    assign div_ovf  = signed_mode && (a_q == MOST_NEG) && (b_q == '1);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        launch = S_IDLE;
        case (opcode)
            OP_ADD, OP_SUB: launch = S_ADDSUB;
            OP_MUL:         launch = S_MUL;
            default:        launch = (B == '0) ? S_DONE : S_DIV;
        endcase
    end

    always_comb begin
        iter_clear = 1'b0;
        iter_load  = 1'b0;
        iter_step  = 1'b0;
        if (state == S_IDLE || state == S_DONE) begin
            iter_clear = start;
        end else if (state == S_MUL || state == S_DIV) begin
            iter_load = iter_first;
            iter_step = !iter_first;
        end
    end

    always_comb begin
        pub_result = '0;
        pub_rem    = '0;
        pub_carry  = 1'b0;
        pub_ovf    = 1'b0;
        pub_dz     = 1'b0;
        case (op_q)
            OP_ADD: begin
                pub_result = {{(WIDTH - 1){1'b0}}, sum};
                pub_carry  = sum[WIDTH];
                pub_ovf    = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                pub_result = {{WIDTH{1'b0}}, diff};
                pub_carry  = (a_q < b_q);
                pub_ovf    = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_MUL: begin
                pub_result = prod;
                pub_carry  = mul_wide;
                pub_ovf    = mul_wide;
            end
            default: begin
                if (b_q == '0) begin
                    pub_result = '1;
                    pub_rem    = a_q;
                    pub_ovf    = 1'b1;
                    pub_dz     = 1'b1;
                end else begin
                    pub_result = {{WIDTH{1'b0}}, quot};
                    pub_rem    = rem;
                    pub_ovf    = div_ovf;
                end
            end
        endcase
    end

    alu_seq_iter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (iter_clear),
        .load   (iter_load),
        .step   (iter_step),
        .is_div (state == S_DIV),
        .a_mag  (a_mag),
        .b_mag  (b_mag),
        .first  (iter_first),
        .last   (iter_last),
        .hi     (hi),
        .lo     (lo)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            busy             <= 1'b0;
            done             <= 1'b0;
            result           <= '0;
            remainder        <= '0;
            carry_flag       <= 1'b0;
            overflow_flag    <= 1'b0;
            div_by_zero_flag <= 1'b0;
            op_q             <= OP_ADD;
            sgn_q            <= 1'b0;
            a_q              <= '0;
            b_q              <= '0;
        end else begin
            done <= (state == S_DONE);
            if (state == S_DONE) begin
                result           <= pub_result;
                remainder        <= pub_rem;
                carry_flag       <= pub_carry;
                overflow_flag    <= pub_ovf;
                div_by_zero_flag <= pub_dz;
            end
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        op_q  <= opcode;
                        sgn_q <= signed_op;
                        a_q   <= A;
                        b_q   <= B;
                        state <= launch;
                        busy  <= (launch != S_DONE);
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                S_ADDSUB: begin
                    state <= S_DONE;
                    busy  <= 1'b0;
                end
                S_MUL, S_DIV: begin
                    if (iter_last) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8, default unsigned build): transaction model
// with per-cycle comparison, directed handshake/reset cases and randomized traffic.
module tb_alu_seq;

    localparam int W = 8;
    localparam logic [1:0] ADD = 2'd0, SUB = 2'd1, MUL = 2'd2, DIV = 2'd3;

    logic           clk = 1'b0, rst_n = 1'b0, start = 1'b0, signed_op = 1'b0;
    logic [1:0]     opcode = 2'd0;
    logic [W-1:0]   A = '0, B = '0;
    logic           busy, done, carry_flag, overflow_flag, div_by_zero_flag;
    logic [2*W-1:0] result;
    logic [W-1:0]   remainder;

    int n_checks = 0;
    int n_fail   = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .opcode           (opcode),
        .signed_op        (signed_op),
        .A                (A),
        .B                (B),
        .busy             (busy),
        .done             (done),
        .result           (result),
        .remainder        (remainder),
        .carry_flag       (carry_flag),
        .overflow_flag    (overflow_flag),
        .div_by_zero_flag (div_by_zero_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    typedef struct {
        int             due;
        int             lat;
        logic [2*W-1:0] res;
        logic [W-1:0]   rem;
        logic           c;
        logic           o;
        logic           z;
    } txn_t;

    // Expected outcome of one operation, straight from the arithmetic definitions.
    function automatic txn_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        txn_t t;
        int ua, ub, sa, sb;
        t  = '{default: 0};
        ua = int'(a);
        ub = int'(b);
        sa = (ua >= 128) ? ua - 256 : ua;
        sb = (ub >= 128) ? ub - 256 : ub;
        case (op)
            ADD: begin
                t.res = 16'(ua + ub);
                t.c   = (ua + ub) > 255;
                t.o   = (sa + sb > 127) || (sa + sb < -128);
                t.lat = 2;
            end
            SUB: begin
                t.res = 16'((ua - ub) & 255);
                t.c   = ua < ub;
                t.o   = (sa - sb > 127) || (sa - sb < -128);
                t.lat = 2;
            end
            MUL: begin
                t.res = 16'(ua * ub);
                t.c   = (ua * ub) > 255;
                t.o   = t.c;
                t.lat = W + 2;
            end
            default: begin
                if (ub == 0) begin
                    t.res = 16'hFFFF;
                    t.rem = a;
                    t.o   = 1'b1;
                    t.z   = 1'b1;
                    t.lat = 1;
                end else begin
                    t.res = 16'(ua / ub);
                    t.rem = 8'(ua % ub);
                    t.lat = W + 2;
                end
            end
        endcase
        return t;
    endfunction

    // Transaction-level expectation: when each accepted op publishes, and when busy is high.
    int   cyc = 0, free_at = 0, busy_lo = 0, busy_hi = -1;
    bit   model_valid = 1'b0;
    bit   exp_done = 1'b0;
    txn_t pend[$];
    txn_t cur = '{default: 0};

    always @(posedge clk) begin
        txn_t t;
        cyc++;
        exp_done = 1'b0;
        if (!rst_n) begin
            pend.delete();
            cur     = '{default: 0};
            free_at = cyc + 1;
            busy_lo = 0;
            busy_hi = -1;
        end else begin
            if (pend.size() > 0 && pend[0].due == cyc) begin
                cur      = pend.pop_front();
                exp_done = 1'b1;
            end
            if (start && cyc >= free_at) begin
                t       = model(opcode, A, B);
                t.due   = cyc + t.lat;
                pend.push_back(t);
                busy_lo = cyc;
                busy_hi = cyc + t.lat - 2;
                free_at = cyc + t.lat;
            end
        end
        model_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check("busy", busy, (cyc >= busy_lo && cyc <= busy_hi));
            check("done", done, exp_done);
            check("result", result, cur.res);
            check("remainder", remainder, cur.rem);
            check("carry", carry_flag, cur.c);
            check("overflow", overflow_flag, cur.o);
            check("div0", div_by_zero_flag, cur.z);
        end
    end

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!done && n < 40);
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int lat, input logic [2*W-1:0] r,
                          input logic [W-1:0] rm, input logic c, input logic o, input logic z);
        int n;
        @(negedge clk);
        opcode = op; A = a; B = b; start = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        A      = ~a;
        B      = ~b;
        opcode = ~op;
        wait_done(n);
        check({name, "_lat"}, n, lat);
        check({name, "_res"}, result, r);
        check({name, "_rem"}, remainder, rm);
        check({name, "_c"}, carry_flag, c);
        check({name, "_o"}, overflow_flag, o);
        check({name, "_z"}, div_by_zero_flag, z);
    endtask

    initial begin
        txn_t t;
        int   n, extra;

        t = model(ADD, 8'd100, 8'd50);
        check("pin_add_res", t.res, 150);
        check("pin_add_ovf", t.o, 1);
        t = model(MUL, 8'd255, 8'd3);
        check("pin_mul_res", t.res, 765);
        check("pin_mul_lat", t.lat, 10);
        t = model(DIV, 8'd10, 8'd0);
        check("pin_dz_res", t.res, 16'hFFFF);

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("add",    ADD, 8'd100, 8'd50,  2,  16'd150,    8'd0,  1'b0, 1'b1, 1'b0);
        run_op("sub",    SUB, 8'd4,   8'd8,   2,  16'h00FC,   8'd0,  1'b1, 1'b0, 1'b0);
        run_op("add_c",  ADD, 8'd255, 8'd1,   2,  16'd256,    8'd0,  1'b1, 1'b0, 1'b0);
        run_op("sub_o",  SUB, 8'd128, 8'd1,   2,  16'h007F,   8'd0,  1'b0, 1'b1, 1'b0);
        run_op("mul",    MUL, 8'd255, 8'd3,   10, 16'd765,    8'd0,  1'b1, 1'b1, 1'b0);
        run_op("mul_sm", MUL, 8'd15,  8'd17,  10, 16'd255,    8'd0,  1'b0, 1'b0, 1'b0);
        run_op("div",    DIV, 8'd200, 8'd7,   10, 16'd28,     8'd4,  1'b0, 1'b0, 1'b0);
        run_op("div1",   DIV, 8'd255, 8'd1,   10, 16'd255,    8'd0,  1'b0, 1'b0, 1'b0);
        run_op("div0",   DIV, 8'd10,  8'd0,   1,  16'hFFFF,   8'd10, 1'b0, 1'b1, 1'b1);

        // start during a multiply is dropped, not queued
        @(negedge clk);
        opcode = MUL; A = 8'd255; B = 8'd3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            n++;
        end
        opcode = ADD; A = 8'd1; B = 8'd1; start = 1'b1;
        @(posedge clk);
        #1;
        n++;
        start = 1'b0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!done && n < 40);
        check("ign_lat", n, 10);
        check("ign_res", result, 765);
        extra = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (done) extra++;
        end
        check("ign_extra", extra, 0);

        // start held through DONE launches the next op back-to-back
        @(negedge clk);
        opcode = ADD; A = 8'd20; B = 8'd30; start = 1'b1;
        @(posedge clk);
        #1;
        opcode = SUB; A = 8'd9; B = 8'd5;
        wait_done(n);
        check("b2b1_lat", n, 2);
        check("b2b1_res", result, 50);
        start = 1'b0;
        wait_done(n);
        check("b2b2_lat", n, 2);
        check("b2b2_res", result, 4);

        // reset in the middle of a multiply
        @(negedge clk);
        opcode = MUL; A = 8'd255; B = 8'd3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mrst_busy", busy, 0);
        check("mrst_done", done, 0);
        check("mrst_res", result, 0);
        check("mrst_rem", remainder, 0);
        check("mrst_flags", {carry_flag, overflow_flag, div_by_zero_flag}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst", ADD, 8'd100, 8'd50, 2, 16'd150, 8'd0, 1'b0, 1'b1, 1'b0);

        // randomized traffic, checked cycle by cycle against the model
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            rst_n     = ($urandom_range(0, 99) != 0);
            start     = ($urandom_range(0, 2) == 0);
            opcode    = 2'($urandom_range(0, 3));
            A         = 8'($urandom);
            B         = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            signed_op = 1'($urandom);
        end
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        repeat (W + 6) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
